conductance_lif_neuron_unit: RTL and testbench
==============================================

# conductance_lif_neuron_unit

Single-neuron state-update datapath for a conductance-based leaky integrate-and-fire neuron. Each enabled clock, it advances one neuron by one Euler step of DeltaT. Inputs are the neuron's stored membrane voltage, conductances, refractory count and incoming weight sums. It returns registered next-state values and a spike flag. It sits between the neuron-state RAMs and the spike buffer, is time-multiplexed across neurons by the controller, and holds no per-neuron state of its own.

## Interface
Parameters:
- INTEGER_WIDTH, 32, integer bits of all fixed-point data and width of integer constants
- DATA_WIDTH_FRAC, 32, fractional bits of state data
- DATA_WIDTH, 64, INTEGER_WIDTH+DATA_WIDTH_FRAC; signed Q32.32 state format
- DELTAT_WIDTH, 4, DeltaT width; unsigned, LSB = 1/16 ms
- TREF_WIDTH, 5, refractory constant width (integer ms)
- EXTEND_WIDTH, 16, (TREF_WIDTH+3)*2; intermediate width for refractory arithmetic

Ports:
- Clock  in  1  sole clock, rising edge
- Reset  in  1  asynchronous, active-high
- UpdateEnable  in  1  perform an update this cycle
- Initialize  in  1  reserved; ignored, may be X
- NeuronType  in  1  0 = excitatory (_EX constants), 1 = inhibitory (_IN constants)
- RestVoltage_EX/_IN, Taumembrane_EX/_IN, ExReversal_EX/_IN, InReversal_EX/_IN, TauExCon_EX/_IN, TauInCon_EX/_IN, ResetVoltage_EX/_IN  in  INTEGER_WIDTH each  signed integer constants (mV, ms)
- Refractory_EX/_IN  in  TREF_WIDTH  refractory period, integer ms, 0..15
- Threshold_EX/_IN  in  DATA_WIDTH  default thresholds; unused by the datapath
- Threshold  in  DATA_WIDTH  this neuron's firing threshold, Q32.32
- Vmem, gex, gin  in  DATA_WIDTH  current state, Q32.32
- RefVal  in  TREF_WIDTH+3  remaining refractory time, LSB = 1/16 ms
- DeltaT  in  DELTAT_WIDTH  time step, LSB = 1/16 ms
- ExWeightSum, InWeightSum  in  DATA_WIDTH  summed incoming weights, Q32.32
- SpikeBuffer  out  1  registered spike flag
- VmemOut, gexOut, ginOut  out  DATA_WIDTH  registered next state
- RefValOut  out  TREF_WIDTH+3  registered next refractory count

## Operation
- Constant set is selected by NeuronType. Integer constants are used as Q32.32 values, i.e. the constant << 32.
- Time step: dt = DeltaT << 28 as Q32.32, so 4'b1000 = 0.5 ms.
- Q32.32 products are computed at full 128 bits and keep bits [95:32], truncated. Q32.32 division by an integer tau uses signed division, truncated toward zero. Results wrap to DATA_WIDTH with no saturation.
- gexN = gex − (gex·dt)/TauExCon + ExWeightSum.
- ginN = gin − (gin·dt)/TauInCon + InWeightSum.
- Conductances update every enabled cycle, including refractory cycles.
- Voltage uses the old gex, gin and Vmem: Vn = Vmem + (dt/Taumembrane)·((Rest−Vmem) + gex·(ExRev−Vmem) + gin·(InRev−Vmem)).
- Refractory case, RefVal ≠ 0: VmemOut = ResetVoltage, RefValOut = max(RefVal − DeltaT, 0), SpikeBuffer = 0.
- Fire case, RefVal = 0 and Vn ≥ Threshold (signed compare): SpikeBuffer = 1, VmemOut = ResetVoltage, RefValOut = Refractory·16, computed at EXTEND_WIDTH and then truncated.
- Integrate case, otherwise: VmemOut = Vn, RefValOut = 0, SpikeBuffer = 0.
- UpdateEnable = 0: VmemOut, gexOut, ginOut and RefValOut hold; SpikeBuffer clears to 0.

## Timing
- All next-state math is combinational from the inputs. All outputs are registered on the rising edge of Clock.
- Latency is 1 cycle from inputs to outputs. A new neuron can be accepted every cycle.
- Reset asserted, at any time including mid-update: all outputs go to 0 immediately. They stay 0 while Reset is high.
- Reset takes priority over UpdateEnable.
- The first enabled edge after Reset falls produces a valid update.

## Test plan
Numeric checks are within 2^-20 of the ideal value unless stated exact.

- **Excitatory leak:** NeuronType=0, Vmem=−105.0, gex=gin=0, weights 0, DeltaT=8, RestVoltage_EX=−65, Taumembrane_EX=100, Threshold=−52.0.
  - VmemOut ≈ −104.8 one cycle later.
  - SpikeBuffer=0, RefValOut=0.
- **Conductance decay plus input:** gex=1.0, TauExCon_EX=1, ExWeightSum=2.0, DeltaT=8 → gexOut=2.5 exact. Then NeuronType=1, gin=1.0, TauInCon_IN=2, InWeightSum=0 → ginOut=0.75 exact.
- **Fire:** NeuronType=0, Vmem=−51.0, Threshold=−52.0, RefVal=0.
  - SpikeBuffer=1, VmemOut=−65.0 exact, RefValOut=80.
  - Same stimulus with Vmem=−52.0 → Vn≈−52.065, no spike.
- **Refractory:** RefVal=80, DeltaT=8 → RefValOut=72, VmemOut=−65.0, SpikeBuffer=0. RefVal=4 → RefValOut=0, saturated.
- **Inhibitory set:** NeuronType=1, Vmem=−100.0, Rest=−60, Taumembrane=10, all g=0 → VmemOut≈−98.0, SpikeBuffer=0.
- **Control:**
  - UpdateEnable=0 for 3 cycles → all state outputs hold and SpikeBuffer=0.
  - Reset pulsed between clock edges → all outputs read 0 before the next edge.
  - Initialize=X → no effect on any output.

Source files
------------

// File: rtl/conductance_lif_neuron_unit.sv
// One Euler step of a conductance-based LIF neuron in Q32.32 fixed point.
// Next state is combinational from the inputs; all outputs are registered.
module conductance_lif_neuron_unit #(
    parameter int INTEGER_WIDTH   = 32,
    parameter int DATA_WIDTH_FRAC = 32,
    parameter int DATA_WIDTH      = 64,
    parameter int DELTAT_WIDTH    = 4,
    parameter int TREF_WIDTH      = 5,
    parameter int EXTEND_WIDTH    = 16
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic                     UpdateEnable,
    input  logic                     Initialize,
    input  logic                     NeuronType,
    input  logic [INTEGER_WIDTH-1:0] RestVoltage_EX,
    input  logic [INTEGER_WIDTH-1:0] RestVoltage_IN,
    input  logic [INTEGER_WIDTH-1:0] Taumembrane_EX,
    input  logic [INTEGER_WIDTH-1:0] Taumembrane_IN,
    input  logic [INTEGER_WIDTH-1:0] ExReversal_EX,
    input  logic [INTEGER_WIDTH-1:0] ExReversal_IN,
    input  logic [INTEGER_WIDTH-1:0] InReversal_EX,
    input  logic [INTEGER_WIDTH-1:0] InReversal_IN,
    input  logic [INTEGER_WIDTH-1:0] TauExCon_EX,
    input  logic [INTEGER_WIDTH-1:0] TauExCon_IN,
    input  logic [INTEGER_WIDTH-1:0] TauInCon_EX,
    input  logic [INTEGER_WIDTH-1:0] TauInCon_IN,
    input  logic [INTEGER_WIDTH-1:0] ResetVoltage_EX,
    input  logic [INTEGER_WIDTH-1:0] ResetVoltage_IN,
    input  logic [TREF_WIDTH-1:0]    Refractory_EX,
    input  logic [TREF_WIDTH-1:0]    Refractory_IN,
    input  logic [DATA_WIDTH-1:0]    Threshold_EX,
    input  logic [DATA_WIDTH-1:0]    Threshold_IN,
    input  logic [DATA_WIDTH-1:0]    Threshold,
    input  logic [DATA_WIDTH-1:0]    Vmem,
    input  logic [DATA_WIDTH-1:0]    gex,
    input  logic [DATA_WIDTH-1:0]    gin,
    input  logic [TREF_WIDTH+2:0]    RefVal,
    input  logic [DELTAT_WIDTH-1:0]  DeltaT,
    input  logic [DATA_WIDTH-1:0]    ExWeightSum,
    input  logic [DATA_WIDTH-1:0]    InWeightSum,
    output logic                     SpikeBuffer,
    output logic [DATA_WIDTH-1:0]    VmemOut,
    output logic [DATA_WIDTH-1:0]    gexOut,
    output logic [DATA_WIDTH-1:0]    ginOut,
    output logic [TREF_WIDTH+2:0]    RefValOut
);

    localparam int RW = TREF_WIDTH + 3;

    typedef logic signed [DATA_WIDTH-1:0]    q_t;
    typedef logic signed [INTEGER_WIDTH-1:0] c_t;

    // Full-width product; low 2N bits are identical for signed and unsigned.
    function automatic q_t f_qmul(input q_t a, input q_t b);
        logic [2*DATA_WIDTH-1:0] p;
        p = {{DATA_WIDTH{a[DATA_WIDTH-1]}}, a} * {{DATA_WIDTH{b[DATA_WIDTH-1]}}, b};
        return q_t'(p[DATA_WIDTH+DATA_WIDTH_FRAC-1:DATA_WIDTH_FRAC]);
    endfunction

    function automatic q_t f_qdiv(input q_t a, input c_t t);
        q_t d;
        d = {{DATA_WIDTH_FRAC{t[INTEGER_WIDTH-1]}}, t};
        return a / d;
    endfunction

    function automatic q_t f_int2q(input c_t c);
        return {c, {DATA_WIDTH_FRAC{1'b0}}};
    endfunction

    c_t                    w_rest, w_taum, w_exrev, w_inrev, w_tauex, w_tauin, w_resetv;
    logic [TREF_WIDTH-1:0] w_refr;
    q_t                    w_dt, w_dt_tau, w_drive, w_vn, w_gex_n, w_gin_n, w_reset_q;
    logic                  w_fire;
    logic [RW-1:0]         w_ref_dec, w_ref_load;
    logic [EXTEND_WIDTH-1:0] w_ref_ext;
    logic                  w_unused;

    assign w_rest   = NeuronType ? RestVoltage_IN  : RestVoltage_EX;
    assign w_taum   = NeuronType ? Taumembrane_IN  : Taumembrane_EX;
    assign w_exrev  = NeuronType ? ExReversal_IN   : ExReversal_EX;
    assign w_inrev  = NeuronType ? InReversal_IN   : InReversal_EX;
    assign w_tauex  = NeuronType ? TauExCon_IN     : TauExCon_EX;
    assign w_tauin  = NeuronType ? TauInCon_IN     : TauInCon_EX;
    assign w_resetv = NeuronType ? ResetVoltage_IN : ResetVoltage_EX;
    assign w_refr   = NeuronType ? Refractory_IN   : Refractory_EX;

    // DeltaT LSB is 1/16 ms, so it sits 4 bits below the binary point.
    assign w_dt      = q_t'({{(DATA_WIDTH-DELTAT_WIDTH){1'b0}}, DeltaT} << (DATA_WIDTH_FRAC-4));
    assign w_reset_q = f_int2q(w_resetv);

    assign w_gex_n  = q_t'(gex) - f_qdiv(f_qmul(q_t'(gex), w_dt), w_tauex) + q_t'(ExWeightSum);
    assign w_gin_n  = q_t'(gin) - f_qdiv(f_qmul(q_t'(gin), w_dt), w_tauin) + q_t'(InWeightSum);
    assign w_dt_tau = f_qdiv(w_dt, w_taum);
    assign w_drive  = (f_int2q(w_rest) - q_t'(Vmem))
                    + f_qmul(q_t'(gex), f_int2q(w_exrev) - q_t'(Vmem))
                    + f_qmul(q_t'(gin), f_int2q(w_inrev) - q_t'(Vmem));
    assign w_vn     = q_t'(Vmem) + f_qmul(w_dt_tau, w_drive);
    assign w_fire   = (RefVal == '0) && (w_vn >= q_t'(Threshold));

    assign w_ref_dec  = (RefVal > RW'(DeltaT)) ? RefVal - RW'(DeltaT) : '0;
    assign w_ref_ext  = EXTEND_WIDTH'(w_refr) << 4;
    assign w_ref_load = w_ref_ext[RW-1:0];

    assign w_unused = ^{Initialize, Threshold_EX, Threshold_IN, w_ref_ext[EXTEND_WIDTH-1:RW]};

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            SpikeBuffer <= 1'b0;
            VmemOut     <= '0;
            gexOut      <= '0;
            ginOut      <= '0;
            RefValOut   <= '0;
        end else if (UpdateEnable) begin
            gexOut <= w_gex_n;
            ginOut <= w_gin_n;
            if (RefVal != '0) begin
                SpikeBuffer <= 1'b0;
                VmemOut     <= w_reset_q;
                RefValOut   <= w_ref_dec;
            end else if (w_fire) begin
                SpikeBuffer <= 1'b1;
                VmemOut     <= w_reset_q;
                RefValOut   <= w_ref_load;
            end else begin
                SpikeBuffer <= 1'b0;
                VmemOut     <= w_vn;
                RefValOut   <= '0;
            end
        end else begin
            SpikeBuffer <= 1'b0;
        end
    end

endmodule

// File: tb/tb_conductance_lif_neuron_unit.sv
// Directed self-checking bench for conductance_lif_neuron_unit.
module tb_conductance_lif_neuron_unit;

    localparam longint TOL = 64'sd4096;

    logic        Clock, Reset, UpdateEnable, Initialize, NeuronType;
    logic [31:0] RestVoltage_EX, RestVoltage_IN, Taumembrane_EX, Taumembrane_IN;
    logic [31:0] ExReversal_EX, ExReversal_IN, InReversal_EX, InReversal_IN;
    logic [31:0] TauExCon_EX, TauExCon_IN, TauInCon_EX, TauInCon_IN;
    logic [31:0] ResetVoltage_EX, ResetVoltage_IN;
    logic [4:0]  Refractory_EX, Refractory_IN;
    logic [63:0] Threshold_EX, Threshold_IN, Threshold, Vmem, gex, gin;
    logic [7:0]  RefVal;
    logic [3:0]  DeltaT;
    logic [63:0] ExWeightSum, InWeightSum;
    logic        SpikeBuffer;
    logic [63:0] VmemOut, gexOut, ginOut;
    logic [7:0]  RefValOut;

    int tests = 0;
    int fails = 0;
    longint d;

    conductance_lif_neuron_unit #(
        .INTEGER_WIDTH(32), .DATA_WIDTH_FRAC(32), .DATA_WIDTH(64),
        .DELTAT_WIDTH(4), .TREF_WIDTH(5), .EXTEND_WIDTH(16)
    ) dut (
        .Clock(Clock), .Reset(Reset), .UpdateEnable(UpdateEnable), .Initialize(Initialize),
        .NeuronType(NeuronType),
        .RestVoltage_EX(RestVoltage_EX), .RestVoltage_IN(RestVoltage_IN),
        .Taumembrane_EX(Taumembrane_EX), .Taumembrane_IN(Taumembrane_IN),
        .ExReversal_EX(ExReversal_EX), .ExReversal_IN(ExReversal_IN),
        .InReversal_EX(InReversal_EX), .InReversal_IN(InReversal_IN),
        .TauExCon_EX(TauExCon_EX), .TauExCon_IN(TauExCon_IN),
        .TauInCon_EX(TauInCon_EX), .TauInCon_IN(TauInCon_IN),
        .ResetVoltage_EX(ResetVoltage_EX), .ResetVoltage_IN(ResetVoltage_IN),
        .Refractory_EX(Refractory_EX), .Refractory_IN(Refractory_IN),
        .Threshold_EX(Threshold_EX), .Threshold_IN(Threshold_IN), .Threshold(Threshold),
        .Vmem(Vmem), .gex(gex), .gin(gin), .RefVal(RefVal), .DeltaT(DeltaT),
        .ExWeightSum(ExWeightSum), .InWeightSum(InWeightSum),
        .SpikeBuffer(SpikeBuffer), .VmemOut(VmemOut), .gexOut(gexOut),
        .ginOut(ginOut), .RefValOut(RefValOut)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Q32.32 encoding of num/den
    function automatic longint q(input longint num, input longint den);
        return (num <<< 32) / den;
    endfunction

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic set_defaults();
        UpdateEnable = 1'b1; Initialize = 1'b0; NeuronType = 1'b0;
        Vmem = q(-65, 1); gex = '0; gin = '0; RefVal = '0; DeltaT = 4'd8;
        ExWeightSum = '0; InWeightSum = '0; Threshold = q(-52, 1);
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        set_defaults();
        step();
        tests++;
        if (VmemOut !== 64'd0 || gexOut !== 64'd0 || ginOut !== 64'd0) begin
            fails++;
            $display("FAIL reset_state: vmem=%h gex=%h gin=%h required all 0", VmemOut, gexOut, ginOut);
        end
        tests++;
        if (SpikeBuffer !== 1'b0 || RefValOut !== 8'd0) begin
            fails++;
            $display("FAIL reset_flags: spike=%b ref=%0d required 0/0", SpikeBuffer, RefValOut);
        end
        #2 Reset = 1'b0;
    endtask

    task automatic test_leak();
        set_defaults();
        Vmem = q(-105, 1);
        step();
        d = longint'(VmemOut) - q(-1048, 10);
        tests++;
        if (d > TOL || d < -TOL) begin
            fails++;
            $display("FAIL leak_vmem: got %h required ~%h", VmemOut, q(-1048, 10));
        end
        tests++;
        if (SpikeBuffer !== 1'b0 || RefValOut !== 8'd0) begin
            fails++;
            $display("FAIL leak_flags: spike=%b ref=%0d required 0/0", SpikeBuffer, RefValOut);
        end
    endtask

    task automatic test_conductance();
        set_defaults();
        gex = q(1, 1); ExWeightSum = q(2, 1);
        step();
        tests++;
        if (gexOut !== q(5, 2)) begin
            fails++;
            $display("FAIL gex_decay: got %h required %h", gexOut, q(5, 2));
        end
        NeuronType = 1'b1; gex = '0; ExWeightSum = '0; gin = q(1, 1); InWeightSum = '0;
        step();
        tests++;
        if (ginOut !== q(3, 4)) begin
            fails++;
            $display("FAIL gin_decay: got %h required %h", ginOut, q(3, 4));
        end
        tests++;
        if (gexOut !== 64'd0) begin
            fails++;
            $display("FAIL gex_zero: got %h required 0", gexOut);
        end
    endtask

    task automatic test_fire();
        set_defaults();
        Vmem = q(-51, 1);
        step();
        tests++;
        if (SpikeBuffer !== 1'b1 || VmemOut !== q(-65, 1) || RefValOut !== 8'd80) begin
            fails++;
            $display("FAIL fire_ex: spike=%b vmem=%h ref=%0d required 1/%h/80",
                     SpikeBuffer, VmemOut, RefValOut, q(-65, 1));
        end
        Vmem = q(-52, 1);
        step();
        d = longint'(VmemOut) - q(-52065, 1000);
        tests++;
        if (SpikeBuffer !== 1'b0 || RefValOut !== 8'd0 || d > TOL || d < -TOL) begin
            fails++;
            $display("FAIL no_fire_edge: spike=%b vmem=%h ref=%0d required 0/~%h/0",
                     SpikeBuffer, VmemOut, RefValOut, q(-52065, 1000));
        end
        NeuronType = 1'b1; Vmem = q(-40, 1);
        step();
        tests++;
        if (SpikeBuffer !== 1'b1 || VmemOut !== q(-60, 1) || RefValOut !== 8'd48) begin
            fails++;
            $display("FAIL fire_in: spike=%b vmem=%h ref=%0d required 1/%h/48",
                     SpikeBuffer, VmemOut, RefValOut, q(-60, 1));
        end
    endtask

    task automatic test_refractory();
        set_defaults();
        Vmem = q(-30, 1); RefVal = 8'd80; gex = q(1, 1);
        step();
        tests++;
        if (RefValOut !== 8'd72 || VmemOut !== q(-65, 1) || SpikeBuffer !== 1'b0) begin
            fails++;
            $display("FAIL refr_count: ref=%0d vmem=%h spike=%b required 72/%h/0",
                     RefValOut, VmemOut, SpikeBuffer, q(-65, 1));
        end
        tests++;
        if (gexOut !== q(1, 2)) begin
            fails++;
            $display("FAIL refr_gex: got %h required %h", gexOut, q(1, 2));
        end
        RefVal = 8'd4;
        step();
        tests++;
        if (RefValOut !== 8'd0 || SpikeBuffer !== 1'b0) begin
            fails++;
            $display("FAIL refr_saturate: ref=%0d spike=%b required 0/0", RefValOut, SpikeBuffer);
        end
    endtask

    task automatic test_inhibitory();
        set_defaults();
        NeuronType = 1'b1; Vmem = q(-100, 1);
        step();
        d = longint'(VmemOut) - q(-98, 1);
        tests++;
        if (d > TOL || d < -TOL || SpikeBuffer !== 1'b0) begin
            fails++;
            $display("FAIL inh_leak: vmem=%h spike=%b required ~%h/0", VmemOut, SpikeBuffer, q(-98, 1));
        end
    endtask

    task automatic test_hold();
        set_defaults();
        Vmem = q(-51, 1); gex = q(1, 1);
        step();
        tests++;
        if (SpikeBuffer !== 1'b1 || gexOut !== q(1, 2)) begin
            fails++;
            $display("FAIL hold_setup: spike=%b gex=%h required 1/%h", SpikeBuffer, gexOut, q(1, 2));
        end
        UpdateEnable = 1'b0; Vmem = q(-100, 1); gex = q(7, 1); gin = q(3, 1); RefVal = 8'd50;
        for (int i = 0; i < 3; i++) begin
            step();
            tests++;
            if (SpikeBuffer !== 1'b0 || VmemOut !== q(-65, 1) || gexOut !== q(1, 2) ||
                ginOut !== 64'd0 || RefValOut !== 8'd80) begin
                fails++;
                $display("FAIL hold_cycle%0d: spike=%b vmem=%h gex=%h gin=%h ref=%0d required 0/%h/%h/0/80",
                         i, SpikeBuffer, VmemOut, gexOut, ginOut, RefValOut, q(-65, 1), q(1, 2));
            end
        end
    endtask

    task automatic test_reset_pulse();
        set_defaults();
        #2 Reset = 1'b1;
        #1;
        tests++;
        if (VmemOut !== 64'd0 || gexOut !== 64'd0 || RefValOut !== 8'd0 || SpikeBuffer !== 1'b0) begin
            fails++;
            $display("FAIL reset_async: vmem=%h gex=%h ref=%0d spike=%b required 0", VmemOut, gexOut, RefValOut, SpikeBuffer);
        end
        Vmem = q(-51, 1);
        step();
        tests++;
        if (VmemOut !== 64'd0 || RefValOut !== 8'd0 || SpikeBuffer !== 1'b0) begin
            fails++;
            $display("FAIL reset_priority: vmem=%h ref=%0d spike=%b required 0", VmemOut, RefValOut, SpikeBuffer);
        end
        Reset = 1'b0;
        Vmem = q(-105, 1);
        step();
        d = longint'(VmemOut) - q(-1048, 10);
        tests++;
        if (d > TOL || d < -TOL) begin
            fails++;
            $display("FAIL post_reset_update: got %h required ~%h", VmemOut, q(-1048, 10));
        end
    endtask

    task automatic test_initialize_x();
        set_defaults();
        Initialize = 1'bx;
        Vmem = q(-51, 1);
        step();
        tests++;
        if (SpikeBuffer !== 1'b1 || VmemOut !== q(-65, 1) || RefValOut !== 8'd80) begin
            fails++;
            $display("FAIL init_x: spike=%b vmem=%h ref=%0d required 1/%h/80", SpikeBuffer, VmemOut, RefValOut, q(-65, 1));
        end
        Initialize = 1'b0;
    endtask

    task automatic test_back_to_back();
        set_defaults();
        Vmem = q(-100, 1); NeuronType = 1'b1;
        step();
        d = longint'(VmemOut) - q(-98, 1);
        NeuronType = 1'b0; Vmem = q(-51, 1);
        tests++;
        if (d > TOL || d < -TOL) begin
            fails++;
            $display("FAIL b2b_first: got %h required ~%h", VmemOut, q(-98, 1));
        end
        step();
        tests++;
        if (SpikeBuffer !== 1'b1 || RefValOut !== 8'd80) begin
            fails++;
            $display("FAIL b2b_second: spike=%b ref=%0d required 1/80", SpikeBuffer, RefValOut);
        end
        RefVal = RefValOut; DeltaT = 4'd15;
        step();
        tests++;
        if (SpikeBuffer !== 1'b0 || RefValOut !== 8'd65 || VmemOut !== q(-65, 1)) begin
            fails++;
            $display("FAIL b2b_third: spike=%b ref=%0d vmem=%h required 0/65/%h", SpikeBuffer, RefValOut, VmemOut, q(-65, 1));
        end
    endtask

    initial begin
        RestVoltage_EX = -32'sd65; Taumembrane_EX = 32'd100; ExReversal_EX = 32'd0;
        InReversal_EX = -32'sd80; TauExCon_EX = 32'd1; TauInCon_EX = 32'd10;
        ResetVoltage_EX = -32'sd65; Refractory_EX = 5'd5;
        RestVoltage_IN = -32'sd60; Taumembrane_IN = 32'd10; ExReversal_IN = 32'd0;
        InReversal_IN = -32'sd80; TauExCon_IN = 32'd5; TauInCon_IN = 32'd2;
        ResetVoltage_IN = -32'sd60; Refractory_IN = 5'd3;
        Threshold_EX = q(-50, 1); Threshold_IN = q(-45, 1);

        test_reset();
        test_leak();
        test_conductance();
        test_fire();
        test_refractory();
        test_inhibitory();
        test_hold();
        test_reset_pulse();
        test_initialize_x();
        test_back_to_back();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
